// File: rtl/one_index_streamer.sv
// Streams the index of every set bit of an accepted vector, one per beat, MSB- or LSB-first.
// Optional popcount output o_count is enabled by defining ONE_STREAM_COUNT_EN.
module one_index_streamer #(
    parameter int DATA_WD = 8,
    parameter int IND_WD  = $clog2(DATA_WD)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_WD-1:0] i_a,
    input  logic               i_mode,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [IND_WD-1:0]  o_index,
    output logic               o_last,
    output logic               o_zero
`ifdef ONE_STREAM_COUNT_EN
    ,
    output logic [IND_WD:0]    o_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [DATA_WD-1:0]   mask_reg, mask_next;
    logic                 mode_reg, mode_next;
    logic                 zero_reg, zero_next;

    logic [IND_WD-1:0]    hi_idx;
    logic [IND_WD-1:0]    lo_idx;
    logic [IND_WD-1:0]    sel_idx;
    logic                 single_bit;
    logic                 emit;
    logic                 accept;
    logic                 beat_fire;

    // Priority encoders over the registered mask only, so outputs never see i_a.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < DATA_WD; i++) begin
            if (mask_reg[i]) begin
                hi_idx = IND_WD'(i);
            end
        end
        for (int i = DATA_WD - 1; i >= 0; i--) begin
            if (mask_reg[i]) begin
                lo_idx = IND_WD'(i);
            end
        end
    end

    assign sel_idx    = mode_reg ? lo_idx : hi_idx;
    assign single_bit = (mask_reg != '0) && ((mask_reg & (mask_reg - DATA_WD'(1))) == '0);
    assign emit       = (state_reg == EMIT);

    assign o_ready   = ~emit;
    assign o_valid   = emit;
    assign o_index   = emit ? sel_idx : '0;
    assign o_last    = emit && (zero_reg || single_bit);
    assign o_zero    = emit && zero_reg;

    assign accept    = i_valid && o_ready;
    assign beat_fire = o_valid && i_ready;

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        mode_next  = mode_reg;
        zero_next  = zero_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    mask_next  = i_a;
                    mode_next  = i_mode;
                    zero_next  = (i_a == '0);
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (beat_fire) begin
                    mask_next = mask_reg & ~(DATA_WD'(1) << sel_idx);
                    if (o_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mask_reg <= '0;
            mode_reg <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            mask_reg <= mask_next;
            mode_reg <= mode_next;
            zero_reg <= zero_next;
        end
    end

`ifdef ONE_STREAM_COUNT_EN
    // Ripple prefix sum of the input bits; only consumed on the accept edge.
    logic [IND_WD:0] psum [DATA_WD+1];
    logic [IND_WD:0] count_reg;

    assign psum[0] = '0;
    for (genvar gi = 0; gi < DATA_WD; gi++) begin : g_pop
        assign psum[gi+1] = psum[gi] + {{IND_WD{1'b0}}, i_a[gi]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_reg <= '0;
        end else if (accept) begin
            count_reg <= psum[DATA_WD];
        end
    end

    assign o_count = count_reg;
`endif

endmodule

// File: tb/tb_one_index_streamer.sv
// Randomized self-checking bench for one_index_streamer at DATA_WD=8 and DATA_WD=16.
// Expected beat sequences come from a queue-based model of the set-bit order.
`timescale 1ns/1ps
module tb_one_index_streamer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a;
    logic        in_mode;
    logic        out_ready;
    int          cur;

    logic        r8, v8, l8, z8;
    logic [2:0]  idx8;
    logic        r16, v16, l16, z16;
    logic [3:0]  idx16;
`ifdef ONE_STREAM_COUNT_EN
    logic [3:0]  c8;
    logic [4:0]  c16;
`endif

    int total;
    int bad;

    one_index_streamer #(.DATA_WD(8)) dut8 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid && (cur == 0)),
        .o_ready (r8),
        .i_a     (in_a[7:0]),
        .i_mode  (in_mode),
        .o_valid (v8),
        .i_ready (out_ready && (cur == 0)),
        .o_index (idx8),
        .o_last  (l8),
        .o_zero  (z8)
`ifdef ONE_STREAM_COUNT_EN
        ,
        .o_count (c8)
`endif
    );

    one_index_streamer #(.DATA_WD(16)) dut16 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid && (cur == 1)),
        .o_ready (r16),
        .i_a     (in_a),
        .i_mode  (in_mode),
        .o_valid (v16),
        .i_ready (out_ready && (cur == 1)),
        .o_index (idx16),
        .o_last  (l16),
        .o_zero  (z16)
`ifdef ONE_STREAM_COUNT_EN
        ,
        .o_count (c16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int obs_ready, obs_valid, obs_index, obs_last, obs_zero, obs_count;
    always_comb begin
        obs_ready = (cur == 1) ? int'(r16)   : int'(r8);
        obs_valid = (cur == 1) ? int'(v16)   : int'(v8);
        obs_index = (cur == 1) ? int'(idx16) : int'(idx8);
        obs_last  = (cur == 1) ? int'(l16)   : int'(l8);
        obs_zero  = (cur == 1) ? int'(z16)   : int'(z8);
`ifdef ONE_STREAM_COUNT_EN
        obs_count = (cur == 1) ? int'(c16)   : int'(c8);
`else
        obs_count = 0;
`endif
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, obs_ready, 1);
        chk({tag, "_valid"}, obs_valid, 0);
        chk({tag, "_index"}, obs_index, 0);
        chk({tag, "_last"},  obs_last,  0);
        chk({tag, "_zero"},  obs_zero,  0);
    endtask

    // pat: 0 = always ready, 1 = ready on every third cycle (1,0,0,1..), 2 = random stalls.
    // rst_after >= 0 asserts reset after that many handshakes.
    task automatic run_vec(input int sel, input logic [15:0] vec, input logic mode,
                           input int pat, input int rst_after);
        int          exp_q[$];
        int          w, hs, cyc, nbeats, guard;
        logic [15:0] v;
        logic        rdy;
        w = (sel == 1) ? 16 : 8;
        v = (sel == 1) ? vec : {8'h00, vec[7:0]};
        if (v == 16'h0) begin
            exp_q.push_back(0);
        end else if (mode == 1'b0) begin
            for (int i = w - 1; i >= 0; i--) if (v[i]) exp_q.push_back(i);
        end else begin
            for (int i = 0; i < w; i++) if (v[i]) exp_q.push_back(i);
        end
        nbeats = exp_q.size();
        cur = sel;
        guard = 0;
        while (obs_ready != 1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", obs_ready, 1);
        in_valid = 1'b1;
        in_a = vec;
        in_mode = mode;
        @(negedge clk);
        in_a = 16'($urandom);
        in_mode = 1'($urandom);
        in_valid = 1'($urandom);
        hs = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            chk("busy_ready", obs_ready, 0);
            chk("beat_valid", obs_valid, 1);
            chk("beat_index", obs_index, exp_q[0]);
            chk("beat_last",  obs_last,  (exp_q.size() == 1) ? 1 : 0);
            chk("beat_zero",  obs_zero,  (v == 16'h0) ? 1 : 0);
`ifdef ONE_STREAM_COUNT_EN
            chk("beat_count", obs_count, $countones(v));
`endif
            if (rst_after >= 0 && hs == rst_after) begin
                rst = 1'b1;
                out_ready = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                out_ready = 1'b0;
                chk("rst_valid", obs_valid, 0);
                chk("rst_ready", obs_ready, 1);
`ifdef ONE_STREAM_COUNT_EN
                chk("rst_count", obs_count, 0);
`endif
                $display("vec sel=%0d a=%h mode=%0d reset after %0d beats", sel, vec, mode, hs);
                return;
            end
            if (pat == 0)      rdy = 1'b1;
            else if (pat == 1) rdy = ((cyc % 3) == 0);
            else               rdy = ($urandom_range(99) >= 40) || (cyc > 200);
            out_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) begin
                void'(exp_q.pop_front());
                hs++;
                if (exp_q.size() == 0) in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("beats_left", exp_q.size(), 0);
        if (pat == 0) chk("beat_cycles", cyc, nbeats);
        chk("end_ready", obs_ready, 1);
        chk("end_valid", obs_valid, 0);
`ifdef ONE_STREAM_COUNT_EN
        chk("end_count", obs_count, $countones(v));
`endif
        $display("vec sel=%0d a=%h mode=%0d pat=%0d beats=%0d cycles=%0d", sel, vec, mode, pat, hs, cyc);
    endtask

    initial begin
        logic [15:0] rv;
        int          kind;
        total = 0;
        bad = 0;
        cur = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 16'h0;
        in_mode = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cur = 0;
            #0 check_idle("idle8");
`ifdef ONE_STREAM_COUNT_EN
            chk("idle8_count", obs_count, 0);
`endif
            cur = 1;
            #0 check_idle("idle16");
        end
        @(negedge clk);

        run_vec(0, 16'h00A6, 1'b0, 0, -1);
        run_vec(0, 16'h00A6, 1'b1, 1, -1);
        run_vec(0, 16'h0000, 1'b0, 0, -1);
        run_vec(0, 16'h0000, 1'b1, 2, -1);
        run_vec(0, 16'h0080, 1'b1, 0, -1);
        run_vec(0, 16'h00FF, 1'b0, 0, -1);
        run_vec(1, 16'h8001, 1'b0, 0, -1);
        run_vec(1, 16'h8001, 1'b1, 2, -1);
        run_vec(0, 16'h00FF, 1'b0, 0, 2);
        run_vec(0, 16'h0010, 1'b0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(9);
            rv = 16'($urandom);
            if (kind == 0)      rv = 16'h0;
            else if (kind == 1) rv = 16'h1 << $urandom_range(15);
            run_vec($urandom_range(1), rv, 1'($urandom), $urandom_range(2), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=1 want=0");
        $fatal(1, "timeout");
    end

endmodule
